rgb_to_ycbcr_stream: RTL and testbench

Pipelined RGB-to-YCbCr colour-space converter that sits directly upstream of the YCbCr frame memory. It accepts one 8-bit RGB pixel per cycle with a valid/ready handshake and converts it with BT.601 full-range (JPEG) fixed-point coefficients. It presents Y/Cb/Cr as 32-bit zero-extended words with a write strobe and memory enable, so the frame memory captures one pixel per asserted write cycle. It counts one frame of NUM_PIXELS, then drains and signals done.

---
 rtl/ycbcr_pkg.sv | 27 ++
 rtl/ycbcr_pipe.sv | 103 ++++++++++
 rtl/rgb_to_ycbcr_stream.sv | 93 +++++++++
 tb/tb_rgb_to_ycbcr_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants and FSM encoding for the RGB-to-YCbCr stream converter.
// Coefficients are BT.601 full-range, scaled by 256.
package ycbcr_pkg;
    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;
    localparam int PROD_W = 18;
    localparam int FRAC_W = 8;
    localparam int ROUND  = 128;
    localparam int OFFSET = 128;

    localparam int C_YR  = 77;
    localparam int C_YG  = 150;
    localparam int C_YB  = 29;
    localparam int C_CBR = 43;
    localparam int C_CBG = 85;
    localparam int C_CBB = 128;
    localparam int C_CRR = 128;
    localparam int C_CRG = 107;
    localparam int C_CRB = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/ycbcr_pipe.sv
// Three-stage RGB-to-YCbCr arithmetic pipeline: multiply, round/shift/offset, clamp.
// A valid bit travels with each pixel; flush drops everything in flight.
module ycbcr_pipe
    import ycbcr_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int COEF_W = PROD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] b,
    output logic [WORD_W-1:0] y_p2,
    output logic [WORD_W-1:0] cb_p2,
    output logic [WORD_W-1:0] cr_p2,
    output logic              vld_p0,
    output logic              vld_p1,
    output logic              vld_p2
);
    localparam logic signed [COEF_W-1:0] K_YR   = COEF_W'(C_YR);
    localparam logic signed [COEF_W-1:0] K_YG   = COEF_W'(C_YG);
    localparam logic signed [COEF_W-1:0] K_YB   = COEF_W'(C_YB);
    localparam logic signed [COEF_W-1:0] K_CBR  = COEF_W'(C_CBR);
    localparam logic signed [COEF_W-1:0] K_CBG  = COEF_W'(C_CBG);
    localparam logic signed [COEF_W-1:0] K_CBB  = COEF_W'(C_CBB);
    localparam logic signed [COEF_W-1:0] K_CRR  = COEF_W'(C_CRR);
    localparam logic signed [COEF_W-1:0] K_CRG  = COEF_W'(C_CRG);
    localparam logic signed [COEF_W-1:0] K_CRB  = COEF_W'(C_CRB);
    localparam logic signed [COEF_W-1:0] K_RND  = COEF_W'(ROUND);
    localparam logic signed [COEF_W-1:0] K_OFS  = COEF_W'(OFFSET);
    localparam logic signed [COEF_W-1:0] K_MAX  = COEF_W'((1 << DATA_W) - 1);

    function automatic logic signed [COEF_W-1:0] round_shift(input logic signed [COEF_W-1:0] v);
        return (v + K_RND) >>> FRAC_W;
    endfunction

    function automatic logic [DATA_W-1:0] sat_pix(input logic signed [COEF_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > K_MAX)
            return '1;
        else
            return v[DATA_W-1:0];
    endfunction

    logic signed [COEF_W-1:0] r_s, g_s, b_s;
    logic signed [COEF_W-1:0] y_p0, cb_p0, cr_p0;
    logic signed [COEF_W-1:0] y_p1, cb_p1, cr_p1;

    assign r_s = COEF_W'(r);
    assign g_s = COEF_W'(g);
    assign b_s = COEF_W'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= in_vld;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage p0: weighted sums of products
    always_ff @(posedge clk) begin
        if (in_vld) begin
            y_p0  <= K_YR * r_s + K_YG * g_s + K_YB * b_s;
            cb_p0 <= K_CBB * b_s - K_CBR * r_s - K_CBG * g_s;
            cr_p0 <= K_CRR * r_s - K_CRG * g_s - K_CRB * b_s;
        end
    end

    // Stage p1: round, scale back to pixel range, centre the chroma
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            y_p1  <= round_shift(y_p0);
            cb_p1 <= round_shift(cb_p0) + K_OFS;
            cr_p1 <= round_shift(cr_p0) + K_OFS;
        end
    end

    // Stage p2: clamp and hold for the frame memory; holds across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p2  <= '0;
            cb_p2 <= '0;
            cr_p2 <= '0;
        end else if (vld_p1 && !flush) begin
            y_p2  <= WORD_W'(sat_pix(y_p1));
            cb_p2 <= WORD_W'(sat_pix(cb_p1));
            cr_p2 <= WORD_W'(sat_pix(cr_p1));
        end
    end
endmodule

// File: rtl/rgb_to_ycbcr_stream.sv
// Frame-level RGB-to-YCbCr converter feeding the YCbCr frame memory:
// handshake, pixel counter and IDLE/RUN/DRAIN/DONE control around ycbcr_pipe.
module rgb_to_ycbcr_stream
    import ycbcr_pkg::*;
#(
    parameter int NUM_PIXELS = 1048576,
    parameter int CNT_W      = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    output logic [31:0] Y_O,
    output logic [31:0] Cb_O,
    output logic [31:0] Cr_O,
    output logic        en_write,
    output logic        mem_enable,
    output logic        busy,
    output logic        done
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             hs, last_hs, frame_go;
    logic             vld_p0, vld_p1, vld_p2;

    assign in_ready = (state == ST_RUN) && enable;
    assign hs       = in_valid && in_ready;
    assign last_hs  = hs && (cnt == CNT_W'(NUM_PIXELS - 1));
    assign frame_go = (state == ST_IDLE) && start && enable;
    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign en_write = vld_p2;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (frame_go) state_nx = ST_RUN;
            ST_RUN:   if (last_hs) state_nx = ST_DRAIN;
            // The final stage retires on this edge, so DONE follows the last write directly
            ST_DRAIN: if (!vld_p0 && !vld_p1) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (!enable)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mem_enable <= 1'b0;
        end else if (!enable) begin
            cnt        <= '0;
            mem_enable <= 1'b0;
        end else if (frame_go) begin
            cnt        <= '0;
            mem_enable <= 1'b1;
        end else if (hs) begin
            cnt        <= cnt + 1'b1;
        end
    end

    ycbcr_pipe #(
        .DATA_W (PIX_W),
        .COEF_W (PROD_W)
    ) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (!enable),
        .in_vld (hs),
        .r      (R_in),
        .g      (G_in),
        .b      (B_in),
        .y_p2   (Y_O),
        .cb_p2  (Cb_O),
        .cr_p2  (Cr_O),
        .vld_p0 (vld_p0),
        .vld_p1 (vld_p1),
        .vld_p2 (vld_p2)
    );
endmodule

// File: tb/tb_rgb_to_ycbcr_stream.sv
// Scoreboard testbench for rgb_to_ycbcr_stream with 8-pixel frames.
module tb_rgb_to_ycbcr_stream;
    localparam int NPIX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  R_in = 8'd0, G_in = 8'd0, B_in = 8'd0;
    logic        in_ready, en_write, mem_enable, busy, done;
    logic [31:0] Y_O, Cb_O, Cr_O;

    int checks = 0;
    int failures = 0;
    int writes = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;

    always #5 clk = ~clk;

    rgb_to_ycbcr_stream #(.NUM_PIXELS(NPIX), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .Y_O(Y_O), .Cb_O(Cb_O), .Cr_O(Cr_O),
        .en_write(en_write), .mem_enable(mem_enable), .busy(busy), .done(done)
    );

    function automatic logic [7:0] clamp8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [23:0] model(input int r, input int g, input int b);
        int y, cb, cr;
        y  = (77 * r + 150 * g + 29 * b + 128) >>> 8;
        cb = ((128 * b - 43 * r - 85 * g + 128) >>> 8) + 128;
        cr = ((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128;
        return {clamp8(y), clamp8(cb), clamp8(cr)};
    endfunction

    // Scoreboard: every write is matched against the oldest expected pixel
    always @(negedge clk) begin
        if (en_write) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got Y/Cb/Cr=%0d/%0d/%0d required no write", Y_O, Cb_O, Cr_O);
            end else begin
                mon_exp = exp_q.pop_front();
                if (Y_O !== {24'd0, mon_exp[23:16]} || Cb_O !== {24'd0, mon_exp[15:8]} ||
                    Cr_O !== {24'd0, mon_exp[7:0]}) begin
                    failures++;
                    $display("FAIL pixel got Y/Cb/Cr=%0d/%0d/%0d required %0d/%0d/%0d",
                             Y_O, Cb_O, Cr_O, mon_exp[23:16], mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        enable = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        writes = 0;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input bit vld, output bit hs);
        R_in = r; G_in = g; B_in = b;
        in_valid = vld;
        hs = vld && in_ready;
        if (hs) exp_q.push_back(model(r, g, b));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin
                seen = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, en_write, mem_enable, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 00000", {in_ready, en_write, mem_enable, busy, done});
        end
        checks++;
        if (Y_O !== 32'd0 || Cb_O !== 32'd0 || Cr_O !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got %0d/%0d/%0d required 0/0/0", Y_O, Cb_O, Cr_O);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency_corners();
        bit hs, seen;
        logic [7:0] px [7][3];
        px = '{'{8'd255, 8'd255, 8'd255}, '{8'd255, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd255},
               '{8'd0, 8'd255, 8'd0}, '{8'd128, 8'd64, 8'd32}, '{8'd10, 8'd200, 8'd90},
               '{8'd255, 8'd255, 8'd0}};
        start_frame();
        checks++;
        if ({mem_enable, busy, in_ready} !== 3'b111) begin
            failures++;
            $display("FAIL run_entry got mem_enable/busy/in_ready=%b required 111", {mem_enable, busy, in_ready});
        end
        send_pixel(8'd0, 8'd0, 8'd0, 1'b1, hs);
        tick();
        checks++;
        if (en_write !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got en_write=%b required 0", en_write);
        end
        tick();
        checks++;
        if (en_write !== 1'b1) begin
            failures++;
            $display("FAIL latency_3 got en_write=%b required 1", en_write);
        end
        for (int i = 0; i < 7; i++) send_pixel(px[i][0], px[i][1], px[i][2], 1'b1, hs);
        wait_done(seen);
        checks++;
        if (!seen || writes != NPIX || busy !== 1'b0) begin
            failures++;
            $display("FAIL corner_frame got done=%0d writes=%0d busy=%b required 1/%0d/0", seen, writes, busy, NPIX);
        end
        tick();
        checks++;
        if (done !== 1'b0 || mem_enable !== 1'b1) begin
            failures++;
            $display("FAIL after_done got done=%b mem_enable=%b required 0/1", done, mem_enable);
        end
    endtask

    task automatic test_random_stream();
        bit hs, seen;
        int n, guard;
        for (int f = 0; f < 125; f++) begin
            start_frame();
            n = 0;
            guard = 0;
            while (n < NPIX && guard < 200) begin
                send_pixel(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
                           $urandom_range(3) != 0, hs);
                if (hs) n++;
                guard++;
            end
            wait_done(seen);
            checks++;
            if (!seen || writes != NPIX) begin
                failures++;
                $display("FAIL random_frame %0d got done=%0d writes=%0d required 1/%0d", f, seen, writes, NPIX);
            end
            tick();
        end
    endtask

    task automatic test_toggle();
        bit hs;
        int n, last_w, done_cyc;
        start_frame();
        n = 0;
        for (int c = 0; c < 40 && n < NPIX; c++) begin
            send_pixel(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
                       (c % 2) == 0, hs);
            if (hs) n++;
        end
        checks++;
        if (in_ready !== 1'b0 || n != NPIX) begin
            failures++;
            $display("FAIL ready_drop got in_ready=%b handshakes=%0d required 0/%0d", in_ready, n, NPIX);
        end
        last_w = -1;
        done_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (en_write) last_w = c;
            if (done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        checks++;
        if (last_w < 0 || done_cyc != last_w + 1 || writes != NPIX || busy !== 1'b0) begin
            failures++;
            $display("FAIL toggle_done got last_write=%0d done_cycle=%0d writes=%0d busy=%b required done=last+1 writes=%0d busy=0",
                     last_w, done_cyc, writes, busy, NPIX);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_abort();
        bit hs, seen, stray;
        start_frame();
        for (int i = 0; i < 3; i++)
            send_pixel(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1, hs);
        enable = 1'b0;
        tick();
        checks++;
        if ({en_write, mem_enable, busy, in_ready} !== 4'b0) begin
            failures++;
            $display("FAIL abort_clear got en_write/mem_enable/busy/in_ready=%b required 0000",
                     {en_write, mem_enable, busy, in_ready});
        end
        exp_q.delete();
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (en_write || done) stray = 1'b1;
            tick();
        end
        checks++;
        if (stray || writes != 1) begin
            failures++;
            $display("FAIL abort_quiet got stray=%0d writes=%0d required 0/1", stray, writes);
        end
        start_frame();
        for (int i = 0; i < NPIX; i++)
            send_pixel(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1, hs);
        wait_done(seen);
        checks++;
        if (!seen || writes != NPIX) begin
            failures++;
            $display("FAIL restart_frame got done=%0d writes=%0d required 1/%0d", seen, writes, NPIX);
        end
        tick();
    endtask

    task automatic test_start_ignore_async_reset();
        bit hs, seen;
        start_frame();
        for (int i = 0; i < 3; i++)
            send_pixel(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1, hs);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++)
            send_pixel(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1, hs);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored got in_ready=%b after 8 handshakes required 0", in_ready);
        end
        wait_done(seen);
        checks++;
        if (!seen || writes != NPIX) begin
            failures++;
            $display("FAIL start_ignored_frame got done=%0d writes=%0d required 1/%0d", seen, writes, NPIX);
        end
        tick();
        start_frame();
        for (int i = 0; i < 2; i++)
            send_pixel(8'd200, 8'd100, 8'd50, 1'b1, hs);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, en_write, mem_enable, busy, done} !== 5'b0 ||
            Y_O !== 32'd0 || Cb_O !== 32'd0 || Cr_O !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got ctrl=%b Y/Cb/Cr=%0d/%0d/%0d required all 0",
                     {in_ready, en_write, mem_enable, busy, done}, Y_O, Cb_O, Cr_O);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency_corners();
        test_random_stream();
        test_toggle();
        test_abort();
        test_start_ignore_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end
endmodule
